// File: rtl/mining_job_loader.sv
// Job front-end for the nonce-search core: collects header and target bytes,
// runs the core under a cycle timeout and hands back the result over valid/ready.
module mining_job_loader #(
    parameter int unsigned BYTE           = 8,
    parameter int unsigned BLOCK_BYTES    = 12,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BYTE-1:0]             in_byte,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        miner_reset,
    output logic [BYTE*BLOCK_BYTES-1:0] miner_data,
    output logic [7:0]                  miner_target,
    input  logic                        miner_finished,
    input  logic [31:0]                 miner_nonce,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic                        res_found,
    output logic [31:0]                 res_nonce,
    output logic [31:0]                 res_cycles,
    output logic                        busy
);
    localparam int CNT_W = $clog2(BLOCK_BYTES + 1);

    typedef enum logic [1:0] {S_LOAD = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [CNT_W-1:0]            r_byte_cnt;
    logic [31:0]                 r_run_cnt;
    logic                        r_miner_reset;
    logic [BYTE*BLOCK_BYTES-1:0] r_data;
    logic [7:0]                  r_target;
    logic                        r_res_valid;
    logic                        r_res_found;
    logic [31:0]                 r_res_nonce;
    logic [31:0]                 r_res_cycles;

    logic                        w_take;
    logic                        w_take_target;
    logic                        w_timeout;
    logic                        w_res_fire;
    logic [BLOCK_BYTES-1:0]      w_lane_we;

    assign in_ready      = (r_state == S_LOAD);
    assign busy          = (r_state != S_LOAD);
    assign w_take        = in_ready & in_valid;
    assign w_take_target = w_take && (r_byte_cnt == CNT_W'(BLOCK_BYTES));
    assign w_timeout     = (r_run_cnt == TIMEOUT_CYCLES - 32'd1);
    assign w_res_fire    = r_res_valid & res_ready;

    // One write strobe per header lane; lane 0 lands in the most significant byte.
    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_BYTES; gi++) begin : g_lane
            assign w_lane_we[gi] = w_take && (r_byte_cnt == CNT_W'(gi));
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LOAD:  if (w_take_target) w_state_next = S_RUN;
            S_RUN:   if (miner_finished || w_timeout) w_state_next = S_DONE;
            S_DONE:  if (w_res_fire) w_state_next = S_LOAD;
            default: w_state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_LOAD;
            r_byte_cnt    <= '0;
            r_run_cnt     <= '0;
            r_miner_reset <= 1'b1;
            r_data        <= '0;
            r_target      <= '0;
            r_res_valid   <= 1'b0;
            r_res_found   <= 1'b0;
            r_res_nonce   <= '0;
            r_res_cycles  <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_LOAD: begin
                    for (int i = 0; i < int'(BLOCK_BYTES); i++) begin
                        if (w_lane_we[i]) r_data[(int'(BLOCK_BYTES) - i)*int'(BYTE) - 1 -: BYTE] <= in_byte;
                    end
                    if (w_take_target) begin
                        r_target      <= in_byte[7:0];
                        r_miner_reset <= 1'b0;
                        r_run_cnt     <= '0;
                    end else if (w_take) begin
                        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    r_run_cnt <= r_run_cnt + 32'd1;
                    // A finish on the timeout cycle still counts as found.
                    if (miner_finished) begin
                        r_res_found   <= 1'b1;
                        r_res_nonce   <= miner_nonce;
                        r_res_cycles  <= r_run_cnt + 32'd1;
                        r_res_valid   <= 1'b1;
                        r_miner_reset <= 1'b1;
                    end else if (w_timeout) begin
                        r_res_found   <= 1'b0;
                        r_res_nonce   <= '0;
                        r_res_cycles  <= TIMEOUT_CYCLES;
                        r_res_valid   <= 1'b1;
                        r_miner_reset <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_res_fire) begin
                        r_res_valid <= 1'b0;
                        r_byte_cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign miner_reset  = r_miner_reset;
    assign miner_data   = r_data;
    assign miner_target = r_target;
    assign res_valid    = r_res_valid;
    assign res_found    = r_res_found;
    assign res_nonce    = r_res_nonce;
    assign res_cycles   = r_res_cycles;
endmodule

// File: tb/tb_mining_job_loader.sv
// Bench for mining_job_loader: scripted and random jobs against a job-level model
// (header packing, found/timeout outcome and cycle count from the finish cycle).
module tb_mining_job_loader;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_byte = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        miner_reset;
    logic [95:0] miner_data;
    logic [7:0]  miner_target;
    logic        miner_finished = 1'b0;
    logic [31:0] miner_nonce = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        res_found;
    logic [31:0] res_nonce;
    logic [31:0] res_cycles;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] job [13];

    always #5 clk = ~clk;

    mining_job_loader #(
        .BYTE(8), .BLOCK_BYTES(12), .TIMEOUT_CYCLES(32'd16)
    ) dut (
        .clk(clk), .reset(reset),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .miner_reset(miner_reset), .miner_data(miner_data), .miner_target(miner_target),
        .miner_finished(miner_finished), .miner_nonce(miner_nonce),
        .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
        .res_nonce(res_nonce), .res_cycles(res_cycles), .busy(busy)
    );

    // Model: header is the first 12 bytes concatenated, first byte most significant.
    function automatic logic [95:0] exp_hdr();
        logic [95:0] h = '0;
        for (int i = 0; i < 12; i++) h = (h << 8) | 96'(job[i]);
        return h;
    endfunction

    function automatic logic exp_found(input int f);
        return (f >= 1 && f <= TMO);
    endfunction

    function automatic int exp_cycles(input int f);
        return exp_found(f) ? f : TMO;
    endfunction

    task automatic randomize_job();
        for (int i = 0; i < 13; i++) job[i] = 8'($urandom);
    endtask

    task automatic push_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_byte  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // gap < 0 selects a random idle gap before each byte.
    task automatic load_job(input int gap);
        for (int i = 0; i < 13; i++) push_byte(job[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
    endtask

    // Core model: finished pulses in RUN cycle f (0 = never). seen = cycle after which
    // res_valid was observed, -1 if it never came within the bound.
    task automatic run_core(input int f, input logic [31:0] nonce, output int seen);
        seen = -1;
        for (int c = 1; c <= TMO + 4; c++) begin
            miner_finished = (c == f);
            miner_nonce    = (c == f) ? nonce : $urandom;
            @(posedge clk); #1;
            if (res_valid) begin seen = c; break; end
        end
        miner_finished = 1'b0;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if ({in_ready, busy, miner_reset, res_valid, res_found} !== 5'b10100) begin
            errors++;
            $display("FAIL reset_flags: got %b want 10100", {in_ready, busy, miner_reset, res_valid, res_found});
        end
        checks++;
        if ({miner_data, miner_target, res_nonce, res_cycles} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%h/%h want all zero", miner_data, miner_target, res_nonce, res_cycles);
        end
    endtask

    task automatic test_load_and_find();
        int seen;
        for (int i = 0; i < 12; i++) job[i] = 8'(i + 1);
        job[12] = 8'h10;
        for (int i = 0; i < 12; i++) push_byte(job[i], 0);
        checks++;
        if ({miner_reset, in_ready, busy} !== 3'b110) begin
            errors++;
            $display("FAIL prelaunch_flags: got %b want 110", {miner_reset, in_ready, busy});
        end
        push_byte(job[12], 0);
        checks++;
        if (miner_data !== 96'h0102030405060708090A0B0C || miner_data !== exp_hdr() || miner_target !== 8'h10) begin
            errors++;
            $display("FAIL basic_job: got %h/%h want 0102030405060708090a0b0c/10", miner_data, miner_target);
        end
        checks++;
        if ({miner_reset, in_ready, busy} !== 3'b001) begin
            errors++;
            $display("FAIL launch_flags: got %b want 001", {miner_reset, in_ready, busy});
        end
        run_core(5, 32'h0000_1234, seen);
        checks++;
        if (seen !== 5) begin
            errors++;
            $display("FAIL found_latency: got %0d want 5", seen);
        end
        checks++;
        if ({res_valid, res_found, miner_reset} !== 3'b111 || res_nonce !== 32'h1234 || res_cycles !== 32'd5) begin
            errors++;
            $display("FAIL found_result: got %b nonce %h cycles %0d want 111 nonce 1234 cycles 5",
                     {res_valid, res_found, miner_reset}, res_nonce, res_cycles);
        end
        consume();
        checks++;
        if ({in_ready, res_valid} !== 2'b10) begin
            errors++;
            $display("FAIL after_consume: got %b want 10", {in_ready, res_valid});
        end
    endtask

    task automatic test_timeout();
        int seen;
        logic [31:0] n;
        randomize_job();
        load_job(0);
        run_core(0, 32'h0, seen);
        checks++;
        if (seen !== TMO || res_found !== 1'b0 || res_nonce !== 32'd0 || res_cycles !== 32'(TMO)) begin
            errors++;
            $display("FAIL timeout: got seen %0d found %b nonce %h cycles %0d want %0d 0 0 %0d",
                     seen, res_found, res_nonce, res_cycles, TMO, TMO);
        end
        consume();
        randomize_job();
        load_job(0);
        n = $urandom;
        run_core(TMO, n, seen);
        checks++;
        if (seen !== TMO || res_found !== 1'b1 || res_nonce !== n || res_cycles !== 32'(TMO)) begin
            errors++;
            $display("FAIL finish_at_timeout: got seen %0d found %b nonce %h cycles %0d want %0d 1 %h %0d",
                     seen, res_found, res_nonce, res_cycles, TMO, n, TMO);
        end
        consume();
    endtask

    task automatic test_hold();
        int seen;
        logic [31:0] n;
        randomize_job();
        load_job(0);
        n = $urandom;
        run_core(3, n, seen);
        // Core keeps finished high with another nonce; DONE must ignore it.
        miner_finished = 1'b1;
        miner_nonce    = ~n;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({res_valid, res_found, in_ready, miner_reset} !== 4'b1101 || res_nonce !== n || res_cycles !== 32'd3) begin
                errors++;
                $display("FAIL hold_cycle%0d: got %b nonce %h cycles %0d want 1101 nonce %h cycles 3",
                         c, {res_valid, res_found, in_ready, miner_reset}, res_nonce, res_cycles, n);
            end
        end
        miner_finished = 1'b0;
        consume();
        checks++;
        if ({in_ready, res_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL hold_release: got %b want 100", {in_ready, res_valid, busy});
        end
    endtask

    task automatic test_gaps();
        int seen;
        randomize_job();
        for (int i = 0; i < 12; i++) push_byte(job[i], 1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL gaps_12bytes_busy: got %b want 0", busy);
        end
        push_byte(job[12], 1);
        checks++;
        if (busy !== 1'b1 || miner_data !== exp_hdr() || miner_target !== job[12]) begin
            errors++;
            $display("FAIL gaps_job: got busy %b %h/%h want 1 %h/%h", busy, miner_data, miner_target, exp_hdr(), job[12]);
        end
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        run_core(4, 32'hABCD, seen);
        in_valid = 1'b0;
        checks++;
        if (miner_data !== exp_hdr() || miner_target !== job[12] || res_cycles !== 32'd4) begin
            errors++;
            $display("FAIL run_ignores_bytes: got %h/%h cycles %0d want %h/%h cycles 4",
                     miner_data, miner_target, res_cycles, exp_hdr(), job[12]);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        int seen;
        logic spurious;
        randomize_job();
        for (int i = 0; i < 7; i++) push_byte(job[i], 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({in_ready, busy, miner_reset, res_valid} !== 4'b1010 || miner_data !== '0) begin
            errors++;
            $display("FAIL reset_midload: got %b data %h want 1010 data 0", {in_ready, busy, miner_reset, res_valid}, miner_data);
        end
        randomize_job();
        load_job(-1);
        checks++;
        if (miner_data !== exp_hdr() || miner_target !== job[12]) begin
            errors++;
            $display("FAIL reload_after_reset: got %h/%h want %h/%h", miner_data, miner_target, exp_hdr(), job[12]);
        end
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        miner_finished = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        miner_finished = 1'b0;
        spurious = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (res_valid !== 1'b0 || in_ready !== 1'b1 || miner_reset !== 1'b1) spurious = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (spurious !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun: got res_valid %b in_ready %b miner_reset %b want 0 1 1", res_valid, in_ready, miner_reset);
        end
        randomize_job();
        load_job(0);
        run_core(2, 32'h5555_AAAA, seen);
        checks++;
        if (seen !== 2 || res_found !== 1'b1 || res_nonce !== 32'h5555_AAAA || miner_data !== exp_hdr()) begin
            errors++;
            $display("FAIL job_after_runreset: got seen %0d found %b nonce %h data %h want 2 1 5555aaaa %h",
                     seen, res_found, res_nonce, miner_data, exp_hdr());
        end
        consume();
    endtask

    task automatic test_random();
        int seen;
        int f;
        logic [31:0] n;
        for (int it = 0; it < 20; it++) begin
            randomize_job();
            load_job(-1);
            f = int'($urandom_range(0, TMO + 4));
            n = $urandom;
            run_core(f, n, seen);
            checks++;
            if (seen !== exp_cycles(f) || res_valid !== 1'b1 || miner_reset !== 1'b1 ||
                res_found !== exp_found(f) || res_cycles !== 32'(exp_cycles(f)) ||
                res_nonce !== (exp_found(f) ? n : 32'd0) ||
                miner_data !== exp_hdr() || miner_target !== job[12]) begin
                errors++;
                $display("FAIL random_job%0d: f %0d got seen %0d found %b nonce %h cycles %0d data %h want found %b nonce %h cycles %0d data %h",
                         it, f, seen, res_found, res_nonce, res_cycles, miner_data,
                         exp_found(f), exp_found(f) ? n : 32'd0, exp_cycles(f), exp_hdr());
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            consume();
            checks++;
            if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL random_consume%0d: got in_ready %b res_valid %b want 1 0", it, in_ready, res_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_and_find();
        test_timeout();
        test_hold();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
